// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
//   Shared GPU definitions for the VRAM access path: address width, the
//   tile/attribute region map and the per-cycle grant-type encoding used by
//   the arbiter.
//   No ports (package).
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

  // VRAM byte address width and data width
  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  // Region map: tiles at 0x0000, attributes at 0x0800, end of used space 0x1800
  localparam logic [VRAM_ADDR_W-1:0] TILE_BASE = 13'h0000;
  localparam logic [VRAM_ADDR_W-1:0] ATTR_BASE = 13'h0800;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_END  = 13'h1800;

  // What the single RAM port is doing this cycle
  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_WRITE = 2'd2,
    GRANT_FORCE = 2'd3
  } grant_e;

  // Both a normal and a starvation-forced write pop the buffer
  function automatic logic is_write_grant(input grant_e g);
    return (g == GRANT_WRITE) || (g == GRANT_FORCE);
  endfunction

  // True when the address falls in the attribute table
  function automatic logic in_attr_region(input logic [VRAM_ADDR_W-1:0] a);
    return (a >= ATTR_BASE) && (a < VRAM_END);
  endfunction

endpackage

// File: rtl/vram_arbiter_write_fifo.sv
// ---------------------------------------------------------------------------
// vram_write_fifo
//   Small circular buffer holding CPU writes ({addr, data}) until the arbiter
//   retires them to VRAM. DEPTH must be a power of two so the pointers wrap
//   naturally.
//   Ports:
//     clk, rst_n         clock, async active-low reset
//     push, push_data    enqueue request (ignored when full)
//     pop                dequeue request (ignored when empty)
//     head_data          oldest entry
//     level              number of entries held
//     full, empty        derived from the registered level only
// ---------------------------------------------------------------------------
module vram_write_fifo
  import vram_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = VRAM_ADDR_W + VRAM_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Guard the requests so a misbehaving caller cannot corrupt the pointers
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (do_push) begin
      entries_d[wr_ptr_q] = push_data;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the level unchanged
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  assign head_data = entries_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares one single-port synchronous VRAM between the renderer (reads) and
//   a buffered CPU write path. Reads normally win; buffered writes drain in
//   idle cycles, and a starvation counter forces a write through after
//   STARVE_LIMIT consecutive denied cycles.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     cpu_wr_valid/addr/data, _ready      CPU write push interface
//     rd_req, rd_addr, rd_ready           renderer read request
//     rd_valid, rd_data                   read result, one cycle after accept
//     mem_en, mem_we, mem_addr, mem_wdata RAM control, combinational
//     mem_rdata                           RAM read data (1-cycle latency)
//     fifo_level                          buffered write count
//     overflow, overflow_clr              sticky dropped-write flag and clear
// ---------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter  int ADDR_W       = VRAM_ADDR_W,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int ENTRY_W = ADDR_W + 8;
  localparam int STV_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0]   starve_q, starve_d;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q, rd_valid_d;
  logic [7:0]         rd_hold_q, rd_hold_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               force_wr, write_grant;
  grant_e             grant;

  // Write buffer
  vram_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({cpu_wr_addr, cpu_wr_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready comes from the registered level, so a same-cycle pop never lets a
  // full buffer accept; an empty buffer cannot pop what it is pushing.
  assign cpu_wr_ready = ~fifo_full;
  assign fifo_push    = cpu_wr_valid & cpu_wr_ready;

  assign force_wr = (starve_q == STARVE_MAX) && !fifo_empty;

  // Grant priority: forced write, then read, then opportunistic write
  always_comb begin
    grant = GRANT_NONE;
    if (force_wr) begin
      grant = GRANT_FORCE;
    end else if (rd_req) begin
      grant = GRANT_READ;
    end else if (!fifo_empty) begin
      grant = GRANT_WRITE;
    end
  end

  assign write_grant = is_write_grant(grant);
  assign fifo_pop    = write_grant;
  assign rd_ready    = rd_req & ~force_wr;

  // RAM port follows the grant combinationally
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GRANT_READ: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GRANT_WRITE, GRANT_FORCE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_head[ENTRY_W-1:8];
        mem_wdata = fifo_head[7:0];
      end
      default: ;
    endcase
  end

  // Starvation counter, sticky overflow and read-return tracking
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || write_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STV_W'(1);
    end

    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end else if (cpu_wr_valid && !cpu_wr_ready) begin
      overflow_d = 1'b1;
    end

    rd_valid_d = (grant == GRANT_READ);
    rd_hold_d  = rd_valid_q ? mem_rdata : rd_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= 8'h00;
    end else begin
      starve_q   <= starve_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  // The RAM returns data one cycle after the access; that cycle is the
  // rd_valid cycle, so the RAM output is presented directly then and the
  // captured copy is held afterwards.
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_rdata : rd_hold_q;
  assign overflow = overflow_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, VRAM byte address width (0x0000-0x17FF tile+attribute space).
REQ-002 Parameter FIFO_DEPTH, default 4, CPU write buffer entries; power of two, 2..16.
REQ-003 Parameter STARVE_LIMIT, default 8, consecutive write-denied cycles before forced write grant.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cpu_wr_valid  input  1  CPU-side write request.
REQ-007 cpu_wr_addr  input  ADDR_W  write byte address.
REQ-008 cpu_wr_data  input  8  write data.
REQ-009 cpu_wr_ready  output  1  buffer can accept; push = valid & ready.
REQ-010 rd_req  input  1  renderer read request.
REQ-011 rd_addr  input  ADDR_W  read byte address.
REQ-012 rd_ready  output  1  read accepted this cycle when rd_req & rd_ready.
REQ-013 rd_valid  output  1  rd_data valid.
REQ-014 rd_data  output  8  read result.
REQ-015 mem_en, mem_we  output  1 each  single-port synchronous RAM enable/write-enable.
REQ-016 mem_addr  output  ADDR_W; mem_wdata  output  8; mem_rdata  input  8 (1-cycle RAM read latency).
REQ-017 fifo_level  output  clog2(FIFO_DEPTH)+1  entries buffered.
REQ-018 overflow  output  1  sticky: push attempted while full; overflow_clr  input  1 clears it.

Function
REQ-019 At most one RAM access per cycle; mem_en/mem_we/mem_addr/mem_wdata driven combinationally from the grant decision.
REQ-020 Grant priority per cycle: forced write (starve counter == STARVE_LIMIT and FIFO non-empty) > read (rd_req) > write (FIFO non-empty) > none.
REQ-021 rd_ready = rd_req & not forced-write; read grant: mem_en=1, mem_we=0, mem_addr=rd_addr.
REQ-022 Write grant pops FIFO head: mem_en=1, mem_we=1, addr/data from head entry.
REQ-023 rd_valid asserts exactly 1 cycle after each accepted read, rd_data = mem_rdata, registered; rd_data holds last value otherwise.
REQ-024 Back-to-back reads each cycle produce back-to-back rd_valid, order preserved.
REQ-025 cpu_wr_ready = (fifo_level < FIFO_DEPTH), from registered count only; a same-cycle pop does not make a full FIFO accept.
REQ-026 Push and pop in same cycle: level unchanged; empty FIFO with push cannot pop same cycle (1-cycle minimum write latency).
REQ-027 Writes retire to RAM in push order; pointers wrap modulo FIFO_DEPTH.
REQ-028 Starve counter: increments when FIFO non-empty and no write granted, saturates at STARVE_LIMIT, clears on any write grant or FIFO empty.
REQ-029 cpu_wr_valid & ~cpu_wr_ready sets overflow; data dropped; overflow_clr has priority over a same-cycle set.
REQ-030 Read to address with pending buffered write returns RAM contents (no forwarding); software orders via fifo_level == 0.

Reset
REQ-031 rst_n low: FIFO pointers/level 0, starve counter 0, rd_valid 0, rd_data 0x00, overflow 0; buffered writes discarded.
REQ-032 Outputs cpu_wr_ready=1, rd_ready=rd_req, mem_en=0 from reset deassertion onward; read in flight at reset produces no rd_valid.

Structure
REQ-033 Shared gpu package holds VRAM address width, region bounds (tile 0x0000, attribute 0x0800, end 0x1800) and grant-type encoding (NONE/READ/WRITE/FORCE).
REQ-034 FIFO is sub-module vram_write_fifo (depth, width ADDR_W+8, level, full/empty); arbitration and starve logic in vram_arbiter.

Verification
REQ-035 Push 0x0123/0xAB with rd_req low -> next cycle mem_we=1, mem_addr=0x0123, mem_wdata=0xAB; fifo_level 1->0.
REQ-036 rd_req held 20 cycles, one write buffered -> write forced at cycle 9 of waiting, rd_ready low that cycle only, reads otherwise every cycle.
REQ-037 Five pushes with rd_req held (depth 4) -> 5th sees cpu_wr_ready=0, overflow=1; overflow_clr -> 0; four writes retire in order.
REQ-038 RAM preloaded 0x0800=0x5A, read 0x0800 -> rd_valid with rd_data=0x5A exactly one cycle after acceptance.
REQ-039 rst_n pulsed low with 3 writes buffered and read in flight -> no mem_we, no rd_valid after release; fifo_level=0.
REQ-040 Full FIFO, simultaneous pop and push attempt -> push refused, overflow set, level 3 after.
